// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shift mode type and pipeline register placement for pipelined_byte_shifter
package shifter_pkg;

    typedef enum logic [1:0] {
        MODE_SHL  = 2'd0,
        MODE_SHR  = 2'd1,
        MODE_ROL  = 2'd2,
        MODE_PASS = 2'd3
    } shift_mode_t;

    // Spreads `levels` registers evenly over `stages` shift stages.
    function automatic bit stage_registered(input int stage, input int levels, input int stages);
        return (((stage + 1) * levels) / stages) > ((stage * levels) / stages);
    endfunction

endpackage

// File: rtl/axi4s_if.sv
// rtl/axi4s_if.sv - AXI4-Stream style bundle with slave/master views
interface AXI4S #(
    parameter int WIDTH = 512
);
    logic [WIDTH-1:0]   tdata;
    logic [WIDTH/8-1:0] tkeep;
    logic               tlast;
    logic               tvalid;
    logic               tready;

    modport s (input tdata, tkeep, tlast, tvalid, output tready);
    modport m (output tdata, tkeep, tlast, tvalid, input tready);
endinterface

// File: rtl/shift_stage.sv
// rtl/shift_stage.sv - one power-of-two byte shift stage, optionally followed by a skid-free register
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH        = 512,
    parameter int BYTES        = WIDTH / 8,
    parameter int OFFSET_WIDTH = $clog2(BYTES),
    parameter int STAGE        = 0,
    parameter bit REGISTER     = 1'b0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [WIDTH-1:0]        s_tdata,
    input  logic [BYTES-1:0]        s_tkeep,
    input  logic                    s_tlast,
    input  logic [OFFSET_WIDTH-1:0] s_offset,
    input  shift_mode_t             s_mode,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [WIDTH-1:0]        m_tdata,
    output logic [BYTES-1:0]        m_tkeep,
    output logic                    m_tlast,
    output logic [OFFSET_WIDTH-1:0] m_offset,
    output shift_mode_t             m_mode,
    output logic                    m_tvalid,
    input  logic                    m_tready
);
    localparam int SHIFT_BYTES = 1 << STAGE;
    localparam int SHIFT_BITS  = 8 * SHIFT_BYTES;

    logic [WIDTH-1:0] data_d;
    logic [BYTES-1:0] keep_d;

    always_comb begin
        data_d = s_tdata;
        keep_d = s_tkeep;
        if (s_offset[STAGE]) begin
            case (s_mode)
                MODE_SHL: begin
                    data_d = s_tdata << SHIFT_BITS;
                    keep_d = s_tkeep << SHIFT_BYTES;
                end
                MODE_SHR: begin
                    data_d = s_tdata >> SHIFT_BITS;
                    keep_d = s_tkeep >> SHIFT_BYTES;
                end
                MODE_ROL: begin
                    data_d = (s_tdata << SHIFT_BITS) | (s_tdata >> (WIDTH - SHIFT_BITS));
                    keep_d = (s_tkeep << SHIFT_BYTES) | (s_tkeep >> (BYTES - SHIFT_BYTES));
                end
                default: ;
            endcase
        end
    end

    if (REGISTER) begin : g_reg
        logic                    valid_q;
        logic [WIDTH-1:0]        data_q;
        logic [BYTES-1:0]        keep_q;
        logic                    last_q;
        logic [OFFSET_WIDTH-1:0] offset_q;
        shift_mode_t             mode_q;
        logic                    load;

        assign load = !valid_q || m_tready;

        always_ff @(posedge aclk) begin
            if (areset) begin
                valid_q <= 1'b0;
            end else if (load) begin
                valid_q <= s_tvalid;
            end
            if (load && s_tvalid) begin
                data_q   <= data_d;
                keep_q   <= keep_d;
                last_q   <= s_tlast;
                offset_q <= s_offset;
                mode_q   <= s_mode;
            end
        end

        // Reset empties the stage, so upstream may be told it is ready immediately.
        assign s_tready = load || areset;
        assign m_tvalid = valid_q;
        assign m_tdata  = data_q;
        assign m_tkeep  = keep_q;
        assign m_tlast  = last_q;
        assign m_offset = offset_q;
        assign m_mode   = mode_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = aclk ^ areset;

        assign s_tready = m_tready;
        assign m_tvalid = s_tvalid;
        assign m_tdata  = data_d;
        assign m_tkeep  = keep_d;
        assign m_tlast  = s_tlast;
        assign m_offset = s_offset;
        assign m_mode   = s_mode;
    end

endmodule

// File: rtl/pipelined_byte_shifter.sv
// rtl/pipelined_byte_shifter.sv - log-stage byte shifter/rotator on AXI4-Stream; SHIFTER_PERF_EN adds beat/stall counters
module pipelined_byte_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH           = 512,
    parameter int BYTES           = WIDTH / 8,
    parameter int OFFSET_WIDTH    = $clog2(BYTES),
    parameter int REGISTER_LEVELS = 0
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [OFFSET_WIDTH-1:0] i_offset,
    input  shift_mode_t             i_mode,
    AXI4S.s                         i_data,
    AXI4S.m                         o_data
`ifdef SHIFTER_PERF_EN
    ,
    output logic [31:0]             o_beat_count,
    output logic [31:0]             o_stall_count
`endif
);
    localparam int STAGES = $clog2(BYTES);

    logic [WIDTH-1:0]        c_data   [STAGES+1];
    logic [BYTES-1:0]        c_keep   [STAGES+1];
    logic                    c_last   [STAGES+1];
    logic [OFFSET_WIDTH-1:0] c_offset [STAGES+1];
    shift_mode_t             c_mode   [STAGES+1];
    logic                    c_valid  [STAGES+1];
    logic                    c_ready  [STAGES+1];

    assign c_data[0]      = i_data.tdata;
    assign c_keep[0]      = i_data.tkeep;
    assign c_last[0]      = i_data.tlast;
    assign c_offset[0]    = i_offset;
    assign c_mode[0]      = i_mode;
    assign c_valid[0]     = i_data.tvalid;
    assign i_data.tready  = c_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shift_stage #(
            .WIDTH        (WIDTH),
            .BYTES        (BYTES),
            .OFFSET_WIDTH (OFFSET_WIDTH),
            .STAGE        (k),
            .REGISTER     (stage_registered(k, REGISTER_LEVELS, STAGES))
        ) u_stage (
            .aclk     (aclk),
            .areset   (areset),
            .s_tdata  (c_data[k]),
            .s_tkeep  (c_keep[k]),
            .s_tlast  (c_last[k]),
            .s_offset (c_offset[k]),
            .s_mode   (c_mode[k]),
            .s_tvalid (c_valid[k]),
            .s_tready (c_ready[k]),
            .m_tdata  (c_data[k+1]),
            .m_tkeep  (c_keep[k+1]),
            .m_tlast  (c_last[k+1]),
            .m_offset (c_offset[k+1]),
            .m_mode   (c_mode[k+1]),
            .m_tvalid (c_valid[k+1]),
            .m_tready (c_ready[k+1])
        );
    end

    assign o_data.tdata    = c_data[STAGES];
    assign o_data.tkeep    = c_keep[STAGES];
    assign o_data.tlast    = c_last[STAGES];
    assign o_data.tvalid   = c_valid[STAGES];
    assign c_ready[STAGES] = o_data.tready;

    logic unused_tail;
    assign unused_tail = ^{c_offset[STAGES], c_mode[STAGES]};

`ifdef SHIFTER_PERF_EN
    logic [31:0] beat_count_q;
    logic [31:0] stall_count_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            beat_count_q  <= '0;
            stall_count_q <= '0;
        end else begin
            if (o_data.tvalid && o_data.tready && (beat_count_q != '1)) begin
                beat_count_q <= beat_count_q + 32'd1;
            end
            if (o_data.tvalid && !o_data.tready && (stall_count_q != '1)) begin
                stall_count_q <= stall_count_q + 32'd1;
            end
        end
    end

    assign o_beat_count  = beat_count_q;
    assign o_stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_pipelined_byte_shifter.sv
// tb/tb_pipelined_byte_shifter.sv - directed and scoreboard bench for pipelined_byte_shifter (512b, 3 register levels)
module tb_pipelined_byte_shifter;
    import shifter_pkg::*;

    localparam int WIDTH = 512;
    localparam int BYTES = 64;
    localparam int OW    = 6;
    localparam int RL    = 3;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [BYTES-1:0] k;
        logic             l;
        int               c;
    } beat_t;

    logic          aclk = 1'b0;
    logic          areset;
    logic [OW-1:0] i_offset;
    shift_mode_t   i_mode;
`ifdef SHIFTER_PERF_EN
    logic [31:0]   beat_count;
    logic [31:0]   stall_count;
`endif

    AXI4S #(.WIDTH(WIDTH)) in_if ();
    AXI4S #(.WIDTH(WIDTH)) out_if ();

    pipelined_byte_shifter #(
        .WIDTH           (WIDTH),
        .REGISTER_LEVELS (RL)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .i_offset (i_offset),
        .i_mode   (i_mode),
        .i_data   (in_if),
        .o_data   (out_if)
`ifdef SHIFTER_PERF_EN
        ,
        .o_beat_count  (beat_count),
        .o_stall_count (stall_count)
`endif
    );

    always #5 aclk = ~aclk;

    int               tests_run    = 0;
    int               tests_failed = 0;
    int               cyc          = 0;
    int               n_out        = 0;
    bit               in_acc       = 1'b0;
    bit               check_lat    = 1'b0;
    bit               prev_stall   = 1'b0;
    logic [WIDTH-1:0] prev_d, last_d;
    logic [BYTES-1:0] prev_k, last_k;
    logic             prev_l, last_l;
    beat_t            expq[$];

    task automatic check_eq(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: byte-by-byte source selection.
    function automatic void model(input logic [WIDTH-1:0] d, input logic [BYTES-1:0] k,
                                  input logic [OW-1:0] n, input shift_mode_t m,
                                  output logic [WIDTH-1:0] od, output logic [BYTES-1:0] ok);
        int nn;
        nn = int'(n);
        od = '0;
        ok = '0;
        for (int j = 0; j < BYTES; j++) begin
            int src;
            bit v;
            case (m)
                MODE_SHL: begin v = (j >= nn);        src = j - nn; end
                MODE_SHR: begin v = (j + nn < BYTES); src = j + nn; end
                MODE_ROL: begin v = 1'b1;             src = (j - nn + BYTES) % BYTES; end
                default:  begin v = 1'b1;             src = j; end
            endcase
            if (v) begin
                od[8*j +: 8] = d[8*src +: 8];
                ok[j]        = k[src];
            end
        end
    endfunction

    task automatic cycle();
        beat_t b;
        @(negedge aclk);
        in_acc = 1'b0;
        if (prev_stall) begin
            check_eq("hold_valid", out_if.tvalid, 1);
            check_eq("hold_data", out_if.tdata, prev_d);
            check_eq("hold_keep", out_if.tkeep, prev_k);
            check_eq("hold_last", out_if.tlast, prev_l);
        end
        if (in_if.tvalid && in_if.tready) begin
            model(in_if.tdata, in_if.tkeep, i_offset, i_mode, b.d, b.k);
            b.l = in_if.tlast;
            b.c = cyc;
            expq.push_back(b);
            in_acc = 1'b1;
        end
        if (out_if.tvalid && out_if.tready) begin
            if (expq.size() == 0) begin
                check_eq("spurious_beat", 1, 0);
            end else begin
                b = expq.pop_front();
                check_eq("sb_data", out_if.tdata, b.d);
                check_eq("sb_keep", out_if.tkeep, b.k);
                check_eq("sb_last", out_if.tlast, b.l);
                if (check_lat) check_eq("latency", cyc - b.c, RL);
            end
            last_d = out_if.tdata;
            last_k = out_if.tkeep;
            last_l = out_if.tlast;
            n_out++;
        end
        prev_stall = out_if.tvalid && !out_if.tready;
        prev_d     = out_if.tdata;
        prev_k     = out_if.tkeep;
        prev_l     = out_if.tlast;
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input bit check_ready);
        areset       = 1'b1;
        in_if.tvalid = 1'b0;
        @(negedge aclk);
        if (check_ready) check_eq("rst_in_ready", in_if.tready, 1);
        @(posedge aclk);
        #1;
        cyc++;
        areset = 1'b0;
        @(negedge aclk);
        check_eq("rst_out_valid", out_if.tvalid, 0);
        expq.delete();
        prev_stall = 1'b0;
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input logic [BYTES-1:0] k, input logic l,
                             input logic [OW-1:0] n, input shift_mode_t m);
        int t;
        t            = 0;
        in_if.tdata  = d;
        in_if.tkeep  = k;
        in_if.tlast  = l;
        i_offset     = n;
        i_mode       = m;
        in_if.tvalid = 1'b1;
        do begin
            cycle();
            t++;
        end while (!in_acc && t < 50);
        if (!in_acc) check_eq("send_timeout", 0, 1);
        in_if.tvalid = 1'b0;
    endtask

    task automatic wait_out(input int target);
        int t;
        t = 0;
        while (n_out < target && t < 50) begin
            cycle();
            t++;
        end
        if (n_out < target) check_eq("out_timeout", n_out, target);
    endtask

    task automatic rand_beat();
        for (int w = 0; w < WIDTH / 32; w++) in_if.tdata[32*w +: 32] = $urandom();
        in_if.tkeep = {$urandom(), $urandom()};
        in_if.tlast = 1'($urandom_range(0, 1));
        i_offset    = OW'($urandom_range(0, BYTES - 1));
        i_mode      = shift_mode_t'($urandom_range(0, 3));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] idx;
        logic [WIDTH-1:0] pat;
        int               sent;
        int               guard;
        int               base;
        int               stalls_left;

        for (int j = 0; j < BYTES; j++) idx[8*j +: 8] = 8'(j);
        in_if.tdata   = '0;
        in_if.tkeep   = '0;
        in_if.tlast   = 1'b0;
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        i_offset      = '0;
        i_mode        = MODE_PASS;
        areset        = 1'b1;

        do_reset(1'b1);
        check_eq("idle_in_ready", in_if.tready, 1);

        // Directed vectors with continuous ready: exact latency is checked too.
        check_lat = 1'b1;
        send_beat(idx, '1, 1'b1, 6'd3, MODE_SHL);
        wait_out(1);
        check_eq("shl_low", last_d[23:0], 24'h0);
        check_eq("shl_b3", last_d[31:24], 8'h00);
        check_eq("shl_b63", last_d[511:504], 8'h3C);
        check_eq("shl_keep", last_k, 64'hFFFF_FFFF_FFFF_FFF8);
        check_eq("shl_last", last_l, 1);

        pat = idx;
        pat[511:504] = 8'hAB;
        send_beat(pat, '1, 1'b0, 6'd63, MODE_SHR);
        wait_out(2);
        check_eq("shr_data", last_d, 512'hAB);
        check_eq("shr_keep", last_k, 64'h1);
        check_eq("shr_last", last_l, 0);

        send_beat(idx, 64'h8000_0000_0000_0001, 1'b0, 6'd1, MODE_ROL);
        wait_out(3);
        check_eq("rol_b0", last_d[7:0], 8'h3F);
        check_eq("rol_b1", last_d[15:8], 8'h00);
        check_eq("rol_b63", last_d[511:504], 8'h3E);
        check_eq("rol_keep", last_k, 64'h3);

        send_beat(idx, 64'h0123_4567_89AB_CDEF, 1'b1, 6'd17, MODE_PASS);
        wait_out(4);
        check_eq("pass_data", last_d, idx);
        check_eq("pass_keep", last_k, 64'h0123_4567_89AB_CDEF);

        send_beat(idx, 64'h0123_4567_89AB_CDEF, 1'b0, 6'd0, MODE_SHL);
        wait_out(5);
        check_eq("n0_data", last_d, idx);
        check_eq("n0_keep", last_k, 64'h0123_4567_89AB_CDEF);

        send_beat(idx, '1, 1'b0, 6'd8, MODE_SHR);
        wait_out(6);
        check_eq("shr8_b0", last_d[7:0], 8'h08);
        check_eq("shr8_b55", last_d[447:440], 8'h3F);
        check_eq("shr8_b56", last_d[455:448], 8'h00);
        check_eq("shr8_keep", last_k, 64'h00FF_FFFF_FFFF_FFFF);

        // Back-to-back beats must each be accepted in one cycle.
        in_if.tvalid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_beat();
            cycle();
            check_eq("tput_accept", in_acc, 1);
        end
        in_if.tvalid = 1'b0;
        wait_out(14);

        // Reset with two beats in flight, then a clean beat afterwards.
        send_beat(idx, '1, 1'b0, 6'd5, MODE_ROL);
        send_beat(idx, '1, 1'b0, 6'd6, MODE_ROL);
        do_reset(1'b1);
        base = n_out;
        send_beat(idx, '1, 1'b1, 6'd2, MODE_SHL);
        wait_out(base + 1);
        check_eq("post_rst_b2", last_d[23:16], 8'h00);
        check_eq("post_rst_b63", last_d[511:504], 8'h3D);
        check_eq("post_rst_count", n_out, base + 1);

        // Fill the pipeline against backpressure, then reset it.
        out_if.tready = 1'b0;
        in_if.tvalid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rand_beat();
            cycle();
        end
        check_eq("full_in_ready", in_if.tready, 0);
        do_reset(1'b1);
        out_if.tready = 1'b1;

        // Random traffic with ~30% output backpressure.
        check_lat    = 1'b0;
        sent         = 0;
        guard        = 0;
        in_acc       = 1'b0;
        in_if.tvalid = 1'b0;
        while (sent < 1000 && guard < 20000) begin
            if (!in_if.tvalid || in_acc) begin
                if (sent < 1000 && $urandom_range(0, 9) < 8) begin
                    rand_beat();
                    in_if.tvalid = 1'b1;
                end else begin
                    in_if.tvalid = 1'b0;
                end
            end
            out_if.tready = ($urandom_range(0, 9) >= 3);
            cycle();
            guard++;
            if (in_acc) sent++;
        end
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        guard = 0;
        while (expq.size() != 0 && guard < 100) begin
            cycle();
            guard++;
        end
        check_eq("rand_sent", sent, 1000);
        check_eq("rand_drained", expq.size(), 0);

`ifdef SHIFTER_PERF_EN
        do_reset(1'b0);
        check_eq("perf_beats_rst", beat_count, 0);
        check_eq("perf_stalls_rst", stall_count, 0);
        base        = n_out;
        sent        = 0;
        guard       = 0;
        stalls_left = 4;
        in_acc      = 1'b0;
        while (n_out - base < 10 && guard < 200) begin
            if (!in_if.tvalid || in_acc) rand_beat();
            in_if.tvalid  = (sent < 10);
            out_if.tready = !(out_if.tvalid && stalls_left > 0);
            if (!out_if.tready) stalls_left--;
            cycle();
            guard++;
            if (in_acc) sent++;
        end
        in_if.tvalid  = 1'b0;
        out_if.tready = 1'b1;
        check_eq("perf_beats", beat_count, 10);
        check_eq("perf_stalls", stall_count, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pipelined_byte_shifter.md
PIPELINED_BYTE_SHIFTER -- requirements
Module: pipelined_byte_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 512, tdata width in bits, a power of two and at least 16.
REQ-002 SHALL have parameter BYTES, default WIDTH/8, the byte lane count.
REQ-003 SHALL have parameter OFFSET_WIDTH, default $clog2(BYTES), the shift amount width.
REQ-004 SHALL have parameter REGISTER_LEVELS, default 0, the number of pipeline registers, legal range 0..$clog2(BYTES).
REQ-005 SHALL have port aclk, input, 1 bit, the single clock.
REQ-006 SHALL have port areset, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL have port i_offset, input, OFFSET_WIDTH bits, the shift amount in bytes, sampled with the i_data beat.
REQ-008 SHALL have port i_mode, input, 2 bits, shift_mode_t, sampled with the i_data beat.
REQ-009 SHALL have port i_data, AXI4S.s, WIDTH bits, the input stream (tdata, tkeep, tlast, tvalid, tready).
REQ-010 SHALL have port o_data, AXI4S.m, WIDTH bits, the output stream.
REQ-011 SHALL have port o_beat_count, output, 32 bits, present only with SHIFTER_PERF_EN.
REQ-012 SHALL have port o_stall_count, output, 32 bits, present only with SHIFTER_PERF_EN.

Function
REQ-013 SHALL define modes MODE_SHL=0, MODE_SHR=1, MODE_ROL=2 and MODE_PASS=3; byte j is tdata[8j+7:8j], and "left" means toward higher j.
REQ-014 In SHL mode, out byte j SHALL equal in byte j-N for j>=N, else 0; tkeep SHALL be shifted identically and zero-filled.
REQ-015 In SHR mode, out byte j SHALL equal in byte j+N for j<BYTES-N, else 0; tkeep SHALL be shifted identically and zero-filled.
REQ-016 In ROL mode, out byte j SHALL equal in byte (j-N) mod BYTES; tkeep SHALL be rotated identically.
REQ-017 In PASS mode, or when N=0 in any mode, tdata and tkeep SHALL pass through unchanged.
REQ-018 tlast SHALL pass through unmodified in every mode.
REQ-019 The shift SHALL be built from $clog2(BYTES) stages, stage k moving data by 2^k bytes when offset bit k is set; offset and mode SHALL travel with the beat.
REQ-020 A register SHALL follow stage i iff floor((i+1)*REGISTER_LEVELS/S) > floor(i*REGISTER_LEVELS/S), where S=$clog2(BYTES), giving exactly REGISTER_LEVELS registers.
REQ-021 Latency from input handshake to o_data.tvalid SHALL be exactly REGISTER_LEVELS cycles; with REGISTER_LEVELS=0 the block SHALL be purely combinational.
REQ-022 Each register SHALL load when it is empty or its downstream is ready, and its upstream ready SHALL be !valid_q || downstream_ready.
REQ-023 Throughput SHALL be one beat per cycle under continuous ready.
REQ-024 No beat SHALL be dropped, duplicated or reordered under arbitrary tready backpressure.
REQ-025 tdata, tkeep, tlast and offset SHALL hold stable while o_data.tvalid is high and o_data.tready is low.

Reset
REQ-026 On areset, every register stage valid SHALL clear to 0 and o_data.tvalid SHALL be 0 on the next cycle.
REQ-027 Reset mid-stream SHALL discard all in-flight beats; data registers need not be reset.
REQ-028 During areset, i_data.tready SHALL be 1 once REGISTER_LEVELS>0 (all stages empty).
REQ-029 Perf counters SHALL reset to 0.

Configuration
REQ-030 With SHIFTER_PERF_EN defined, o_beat_count SHALL increment on each o_data handshake and o_stall_count on each cycle with o_data.tvalid=1 and o_data.tready=0.
REQ-031 Both counters SHALL saturate at 2^32-1.
REQ-032 Without SHIFTER_PERF_EN, the counter ports and logic SHALL be absent and the data path SHALL be unchanged.

Structure
REQ-033 Package shifter_pkg SHALL hold shift_mode_t and the function computing the register placement for REQ-020.
REQ-034 Sub-module shift_stage SHALL implement one power-of-two stage, parameterised by stage index and a REGISTER flag, carrying offset and mode.

Verification
REQ-035 WIDTH=512, SHL, N=3, tdata bytes = index, tkeep all ones -> out bytes 0..2 = 0, byte 3 = 0x00, byte 63 = 0x3C, tkeep = 0xFFFF_FFFF_FFFF_FFF8.
REQ-036 SHR, N=63, byte 63=0xAB -> out byte 0 = 0xAB, all other bytes 0, tkeep = 0x1.
REQ-037 ROL, N=1, bytes = index -> out byte 0 = 0x3F, byte 1 = 0x00; PASS with N=17 -> identical to input.
REQ-038 REGISTER_LEVELS=3, 1000 random beats, random tready at 30% low -> scoreboard exact match, latency 3, no loss.
REQ-039 Assert areset with 2 beats in flight -> o_data.tvalid=0 next cycle; the following beats emerge unaffected.
REQ-040 SHIFTER_PERF_EN, 10 beats with 4 stall cycles -> o_beat_count=10, o_stall_count=4.
